timer_scheduler: RTL and testbench
==================================

// Module: timer_scheduler
// PURPOSE
//  Shares one seconds timebase among N_REQ requesters (door hold, travel, idle-return, ...).
//  Each requester asks for a timeout of req_secs seconds.
//  Round-robin arbitration picks one requester at a time; a prescaler counts that requester's seconds.
//  When its time runs out, the block pulses that requester's done bit.
//  Sits between the elevator control FSMs and the system clock; it replaces per-FSM free-running timers.
// PARAMETERS
//  N_REQ          4         number of requesters (2..8)
//  TICKS_PER_SEC  50000000  clk cycles per second (bench uses 4)
//  SEC_W          4         width of one seconds field
// PORTS
//  clk        in   1            system clock, all state on rising edge
//  reseta     in   1            asynchronous reset, ACTIVE-LOW (0 = reset)
//  req        in   N_REQ        level request per requester; held until done or cancel
//  req_secs   in   N_REQ*SEC_W  field i = [i*SEC_W +: SEC_W], timeout in seconds; sampled at grant
//  grant      out  N_REQ        one-hot, requester currently being timed (0 when none)
//  done       out  N_REQ        one-cycle pulse to requester whose timeout expired
//  busy       out  1            1 while in COUNT or DONE
//  remaining  out  SEC_W        seconds left for the granted requester (0 when idle)
//  sec_tick   out  1            one-cycle pulse on each elapsed second while counting
// BEHAVIOUR
//  Reset (reseta=0, async): state=IDLE, grant=0, done=0, busy=0, remaining=0, sec_tick=0, prescaler=0, rr_ptr=0.
//    Reset mid-count aborts the timeout silently; no done pulse is produced.
//  States: IDLE, COUNT, DONE. All outputs are registered.
//  IDLE: if req!=0 at an edge, pick the winner w = first set bit of req searching from rr_ptr upward, with wrap.
//    Same edge: remaining<=req_secs[w], prescaler<=0.
//    If req_secs[w]!=0: grant<=onehot(w), state<=COUNT.
//    If req_secs[w]==0: grant stays 0, done[w]<=1, state<=DONE (zero-second request completes immediately).
//  COUNT: prescaler increments each cycle.
//    At prescaler==TICKS_PER_SEC-1: prescaler<=0, sec_tick<=1 for 1 cycle, remaining<=remaining-1.
//    If remaining was 1: grant<=0, done[w]<=1, state<=DONE.
//    Cancel: if req[w]==0 at an edge, that edge sets grant<=0 and remaining<=0, skips DONE, and goes to IDLE.
//      Cancel takes priority over expiry on the same edge.
//      rr_ptr<=w+1 mod N_REQ.
//    req_secs[w] changes after the grant are ignored. Other requests wait; their req must stay high.
//  DONE: lasts exactly 1 cycle. done=onehot(w), remaining=0. Next edge: done<=0, rr_ptr<=w+1 mod N_REQ, state<=IDLE.
//  Latency: for secs>=1, done rises exactly secs*TICKS_PER_SEC cycles after grant rises.
//    The next grant can rise 1 cycle after done falls (IDLE is visited for >=1 cycle).
//  Fairness: a continuously-requesting requester is served within N_REQ-1 other timeouts.
//  Width: prescaler width = $clog2(TICKS_PER_SEC); remaining never underflows.
//  busy = (state!=IDLE).
// TESTING (TICKS_PER_SEC=4, N_REQ=4, SEC_W=4)
//  1 Reset: hold reseta=0 with req=4'b1111 -> all outputs 0. Release -> grant=0001 on the next edge.
//  2 req[0], secs=2 -> grant=0001; sec_tick at +4 and +8 cycles; done=0001 for 1 cycle exactly 8 cycles after grant; remaining goes 2,1,0.
//  3 req=1111, all secs=1 -> grants in order 0001,0010,0100,1000,0001; each done 4 cycles after its grant.
//  4 req[2], secs=0 -> done=0100 one cycle after the sample edge; grant never asserts; busy high 1 cycle.
//  5 Cancel: req[1] secs=3, drop req[1] at cycle 6 -> grant=0 next edge; no done; rr_ptr=2.
//    Cancel on the exact expiry edge -> no done.
//  6 Async reset mid-COUNT (reseta=0 between edges) -> outputs 0 immediately, no done; after release, pending req is re-granted with full secs.

Source files
------------

// File: rtl/timer_scheduler.sv
// Shared seconds timebase: round-robin picks one requester, counts its timeout
// in whole seconds through a prescaler, then pulses that requester's done bit.
module timer_scheduler #(
   parameter int N_REQ         = 4,
   parameter int TICKS_PER_SEC = 50000000,
   parameter int SEC_W         = 4
) (
   input  logic                     clk,
   input  logic                     reseta,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*SEC_W-1:0]   req_secs,
   output logic [N_REQ-1:0]         grant,
   output logic [N_REQ-1:0]         done,
   output logic                     busy,
   output logic [SEC_W-1:0]         remaining,
   output logic                     sec_tick
);

   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int IW = $clog2(N_REQ);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

   typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [N_REQ-1:0]   done_q, done_d;
   logic [SEC_W-1:0]   remaining_q, remaining_d;
   logic               sec_tick_q, sec_tick_d;
   logic [PW-1:0]      presc_q, presc_d;
   logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]      win_q, win_d;

   logic [IW-1:0]      pick;
   logic               pick_vld;
   logic [SEC_W-1:0]   pick_secs;
   logic [IW-1:0]      ptr_after_win;
   logic               cancel;
   logic               sec_edge;
   logic               last_sec;
   int                 idx;

   // Scan downward so the lowest offset from rr_ptr is the last (winning) write.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      idx      = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr_q) + k) % N_REQ;
         if (req[idx]) begin
            pick     = IW'(idx);
            pick_vld = 1'b1;
         end
      end
   end

   assign pick_secs     = req_secs[int'(pick)*SEC_W +: SEC_W];
   assign ptr_after_win = (int'(win_q) == N_REQ - 1) ? '0 : win_q + IW'(1);
   assign cancel        = (state_q == S_COUNT) && !req[win_q];
   assign sec_edge      = (state_q == S_COUNT) && !cancel && (presc_q == PRESC_LAST);
   assign last_sec      = remaining_q <= SEC_W'(1);

   always_ff @(posedge clk or negedge reseta) begin
      if (!reseta) begin
         state_q     <= S_IDLE;
         grant_q     <= '0;
         done_q      <= '0;
         remaining_q <= '0;
         sec_tick_q  <= 1'b0;
         presc_q     <= '0;
         rr_ptr_q    <= '0;
         win_q       <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         done_q      <= done_d;
         remaining_q <= remaining_d;
         sec_tick_q  <= sec_tick_d;
         presc_q     <= presc_d;
         rr_ptr_q    <= rr_ptr_d;
         win_q       <= win_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (pick_vld) state_d = (pick_secs == '0) ? S_DONE : S_COUNT;
         S_COUNT: begin
            if (cancel)                    state_d = S_IDLE;
            else if (sec_edge && last_sec) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      grant_d     = grant_q;
      done_d      = '0;
      remaining_d = remaining_q;
      sec_tick_d  = 1'b0;
      presc_d     = presc_q;
      rr_ptr_d    = rr_ptr_q;
      win_d       = win_q;
      case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               win_d       = pick;
               remaining_d = pick_secs;
               presc_d     = '0;
               if (pick_secs != '0) grant_d = N_REQ'(1) << pick;
               else                 done_d  = N_REQ'(1) << pick;
            end
         end
         S_COUNT: begin
            if (cancel) begin
               grant_d     = '0;
               remaining_d = '0;
               presc_d     = '0;
               rr_ptr_d    = ptr_after_win;
            end else if (sec_edge) begin
               presc_d     = '0;
               sec_tick_d  = 1'b1;
               remaining_d = last_sec ? '0 : remaining_q - SEC_W'(1);
               if (last_sec) begin
                  grant_d = '0;
                  done_d  = grant_q;
               end
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
         S_DONE: begin
            remaining_d = '0;
            rr_ptr_d    = ptr_after_win;
         end
         default: begin
            grant_d     = '0;
            remaining_d = '0;
         end
      endcase
   end

   assign grant     = grant_q;
   assign done      = done_q;
   assign busy      = (state_q != S_IDLE);
   assign remaining = remaining_q;
   assign sec_tick  = sec_tick_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Bench for timer_scheduler: directed vector table, hand sequences for cancel and
// reset corners, and randomized traffic checked against an elapsed-time model.
module tb_timer_scheduler;

   localparam int N   = 4;
   localparam int TPS = 4;
   localparam int SW  = 4;

   logic          clk = 1'b0;
   logic          reseta = 1'b0;
   logic [N-1:0]  req = '0;
   logic [N*SW-1:0] req_secs = '0;
   logic [N-1:0]  grant, done;
   logic          busy;
   logic [SW-1:0] remaining;
   logic          sec_tick;

   int n_tests = 0;
   int n_fail  = 0;

   timer_scheduler #(.N_REQ(N), .TICKS_PER_SEC(TPS), .SEC_W(SW)) dut (
      .clk(clk), .reseta(reseta), .req(req), .req_secs(req_secs),
      .grant(grant), .done(done), .busy(busy), .remaining(remaining), .sec_tick(sec_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks owner, sampled seconds and cycles elapsed since grant.
   int m_phase = 0;   // 0 idle, 1 timing, 2 done pulse
   int m_w = 0, m_secs = 0, m_el = 0, m_ptr = 0, m_tick = 0;
   logic [N-1:0]    m_r;
   logic [N*SW-1:0] m_s;

   always @(posedge clk) begin
      m_r = req;
      m_s = req_secs;
      if (!reseta) begin
         m_phase = 0; m_ptr = 0; m_tick = 0;
      end else begin
         case (m_phase)
            0: begin
               m_tick = 0;
               if (m_r != 0) begin
                  for (int k = N - 1; k >= 0; k--)
                     if (m_r[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
                  m_secs  = int'(m_s[m_w*SW +: SW]);
                  m_el    = 0;
                  m_phase = (m_secs == 0) ? 2 : 1;
               end
            end
            1: begin
               if (!m_r[m_w]) begin
                  m_phase = 0; m_ptr = (m_w + 1) % N; m_tick = 0;
               end else begin
                  m_el++;
                  m_tick = (m_el % TPS == 0) ? 1 : 0;
                  if (m_el == m_secs * TPS) m_phase = 2;
               end
            end
            default: begin
               m_phase = 0; m_ptr = (m_w + 1) % N; m_tick = 0;
            end
         endcase
      end
      #1;
      chk("model_grant", grant, (m_phase == 1) ? (32'd1 << m_w) : 32'd0);
      chk("model_done", done, (m_phase == 2) ? (32'd1 << m_w) : 32'd0);
      chk("model_busy", busy, (m_phase != 0) ? 32'd1 : 32'd0);
      chk("model_remaining", remaining, (m_phase == 1) ? m_secs - m_el / TPS : 0);
      chk("model_sec_tick", sec_tick, m_tick);
   end

   typedef struct {
      logic [N-1:0]    req;
      logic [N*SW-1:0] secs;
      logic [N-1:0]    grant;
      logic [N-1:0]    done;
      logic            busy;
      logic [SW-1:0]   rem;
      logic            tick;
   } vec_t;

   vec_t tv[12];
   logic [N-1:0] exp_order[5];

   initial begin
      int gi, cyc, gcyc, bud;
      logic [N-1:0] prev_g, last_g;

      // req0 for 2 s, then a zero-second request on req2
      for (int i = 0; i < 4; i++) tv[i] = '{4'b0001, 16'h0002, 4'b0001, 4'b0000, 1'b1, 4'd2, 1'b0};
      tv[4] = '{4'b0001, 16'h0002, 4'b0001, 4'b0000, 1'b1, 4'd1, 1'b1};
      for (int i = 5; i < 8; i++) tv[i] = '{4'b0001, 16'h0002, 4'b0001, 4'b0000, 1'b1, 4'd1, 1'b0};
      tv[8]  = '{4'b0001, 16'h0002, 4'b0000, 4'b0001, 1'b1, 4'd0, 1'b1};
      tv[9]  = '{4'b0000, 16'h0002, 4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0};
      tv[10] = '{4'b0100, 16'h0000, 4'b0000, 4'b0100, 1'b1, 4'd0, 1'b0};
      tv[11] = '{4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0};
      exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      // Reset held with all requests pending
      reseta = 1'b0; req = 4'b1111; req_secs = 16'h1111;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_grant", grant, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_remaining", remaining, 0);
      chk("rst_sec_tick", sec_tick, 0);
      @(negedge clk) reseta = 1'b1;
      @(posedge clk) #1;
      chk("rst_release_grant", grant, 4'b0001);

      // Round robin over all four, 1 s each
      gi = 1; cyc = 0; gcyc = 0; last_g = grant; prev_g = grant;
      while (gi < 5 && cyc < 200) begin
         @(posedge clk) #1;
         cyc++;
         if (done != 0) begin
            chk("rr_done_who", done, last_g);
            chk("rr_done_latency", cyc - gcyc, 4);
         end
         if (grant != 0 && prev_g == 0) begin
            chk("rr_order", grant, exp_order[gi]);
            gi++; last_g = grant; gcyc = cyc;
         end
         prev_g = grant;
      end
      chk("rr_all_granted", gi, 5);
      @(negedge clk) req = '0;
      repeat (3) @(negedge clk);

      // Vector table
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         req = tv[i].req; req_secs = tv[i].secs;
         @(posedge clk) #1;
         chk($sformatf("vec%0d_grant", i), grant, tv[i].grant);
         chk($sformatf("vec%0d_done", i), done, tv[i].done);
         chk($sformatf("vec%0d_busy", i), busy, tv[i].busy);
         chk($sformatf("vec%0d_remaining", i), remaining, tv[i].rem);
         chk($sformatf("vec%0d_sec_tick", i), sec_tick, tv[i].tick);
      end

      // Cancel mid-count: req1 for 3 s, dropped before the 6th edge
      @(negedge clk) begin req = 4'b0010; req_secs = 16'h0030; end
      @(posedge clk) #1;
      chk("cxl_grant", grant, 4'b0010);
      repeat (5) @(posedge clk);
      @(negedge clk) req = '0;
      @(posedge clk) #1;
      chk("cxl_grant_off", grant, 0);
      chk("cxl_busy", busy, 0);
      chk("cxl_remaining", remaining, 0);
      chk("cxl_no_done", done, 0);
      repeat (3) begin
         @(posedge clk) #1;
         chk("cxl_no_done_later", done, 0);
      end
      // rr_ptr now 2: with req 1011 the winner is 3
      @(negedge clk) begin req = 4'b1011; req_secs = 16'h1111; end
      @(posedge clk) #1;
      chk("cxl_rr_ptr", grant, 4'b1000);
      @(negedge clk) req = '0;
      repeat (2) @(negedge clk);

      // Cancel on the exact expiry edge
      @(negedge clk) begin req = 4'b0001; req_secs = 16'h0001; end
      @(posedge clk) #1;
      chk("cxl_exp_grant", grant, 4'b0001);
      repeat (3) @(posedge clk);
      @(negedge clk) req = '0;
      @(posedge clk) #1;
      chk("cxl_exp_done", done, 0);
      chk("cxl_exp_grant_off", grant, 0);
      @(posedge clk) #1;
      chk("cxl_exp_done_after", done, 0);

      // Async reset in the middle of a count
      @(negedge clk) begin req = 4'b0100; req_secs = 16'h0200; end
      @(posedge clk) #1;
      chk("ar_grant", grant, 4'b0100);
      chk("ar_remaining", remaining, 2);
      repeat (5) @(posedge clk);
      @(negedge clk) #2 reseta = 1'b0;
      #1;
      chk("ar_imm_grant", grant, 0);
      chk("ar_imm_busy", busy, 0);
      chk("ar_imm_remaining", remaining, 0);
      chk("ar_imm_done", done, 0);
      @(posedge clk);
      @(negedge clk) reseta = 1'b1;
      @(posedge clk) #1;
      chk("ar_regrant", grant, 4'b0100);
      chk("ar_regrant_secs", remaining, 2);
      bud = 0;
      while (done == 0 && bud < 20) begin
         @(posedge clk) #1;
         bud++;
      end
      chk("ar_done_latency", bud, 8);
      chk("ar_done_who", done, 4'b0100);
      @(negedge clk) req = '0;
      repeat (3) @(negedge clk);

      // Random traffic against the model
      for (int c = 0; c < 600; c++) begin
         int b;
         @(negedge clk);
         if ($urandom_range(0, 5) == 0) begin
            b = int'($urandom_range(0, N - 1));
            req[b] = ~req[b];
         end
         req_secs = 16'($urandom) & 16'h3333;
      end
      @(negedge clk) req = '0;
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
